ps2_mouse_rx: RTL

Physical-layer PS/2 mouse receiver feeding the Mac quadrature mouse stage. Samples the raw PS/2 clock/data pins, deserialises 11-bit frames, checks parity and framing, and assembles 3-byte movement packets. Publishes each packet on a 25-bit bus whose bit 24 toggles once per packet. Optionally sends the stream-enable command (0xF4) after reset.

---
 rtl/ps2_mouse_rx.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: synchronised, glitch-filtered pins -> 11-bit frames -> 3-byte packets on a toggle bus.
// Define PS2_MOUSE_INIT_EN to send the stream-enable command (0xF4) after reset and wait for 0xFA.
module ps2_mouse_rx #(
  parameter int FILTER      = 8,
  parameter int TIMEOUT     = 8000,
  parameter int INHIBIT_CYC = 4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic        ps2_clk_oe,
  output logic        ps2_data_oe,
  output logic [24:0] ps2_mouse,
  output logic        err
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;

  logic [1:0]    clk_sync_reg;
  logic [1:0]    data_sync_reg;
  logic          filt_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          fall_reg;
  logic [TW-1:0] to_cnt_reg;

  rx_state_t     rx_state_reg;
  logic [3:0]    bitcnt_reg;
  logic [7:0]    shift_reg;
  logic          parity_reg;
  logic [1:0]    idx_reg;
  logic [7:0]    byte0_reg;
  logic [7:0]    byte1_reg;
  logic [24:0]   mouse_reg;
  logic          err_reg;

  logic clk_s, data_s;
  logic timeout_hit, frame_ok, good_byte;
  logic rx_enable, pkt_enable, to_clear;

  assign clk_s  = clk_sync_reg[1];
  assign data_s = data_sync_reg[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2_clk_i};
      data_sync_reg <= {data_sync_reg[0], ps2_data_i};
    end
  end

  // Level changes only after FILTER consecutive disagreeing samples; fall_reg marks a 1->0 change.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_reg     <= 1'b1;
      filt_cnt_reg <= '0;
      fall_reg     <= 1'b0;
    end else begin
      fall_reg <= 1'b0;
      if (clk_s != filt_reg) begin
        if (filt_cnt_reg == FW'(FILTER - 1)) begin
          filt_reg     <= clk_s;
          filt_cnt_reg <= '0;
          fall_reg     <= ~clk_s;
        end else begin
          filt_cnt_reg <= filt_cnt_reg + 1'b1;
        end
      end else begin
        filt_cnt_reg <= '0;
      end
    end
  end

  // A fall on the same cycle wins over the timeout.
  assign timeout_hit = !fall_reg && (to_cnt_reg == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || fall_reg || to_clear) begin
      to_cnt_reg <= '0;
    end else if (to_cnt_reg != TW'(TIMEOUT)) begin
      to_cnt_reg <= to_cnt_reg + 1'b1;
    end
  end

  assign frame_ok  = (^{shift_reg, parity_reg}) && data_s;
  assign good_byte = fall_reg && (rx_state_reg == RX_RECV) && (bitcnt_reg == 4'd9) && frame_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_reg <= RX_IDLE;
      bitcnt_reg   <= '0;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      idx_reg      <= '0;
      byte0_reg    <= '0;
      byte1_reg    <= '0;
      mouse_reg    <= '0;
      err_reg      <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      if (!rx_enable) begin
        rx_state_reg <= RX_IDLE;
        idx_reg      <= '0;
      end else if (fall_reg) begin
        case (rx_state_reg)
          RX_IDLE: begin
            if (!data_s) begin
              rx_state_reg <= RX_RECV;
              bitcnt_reg   <= '0;
            end
          end
          default: begin
            bitcnt_reg <= bitcnt_reg + 1'b1;
            if (bitcnt_reg < 4'd8) begin
              shift_reg <= {data_s, shift_reg[7:1]};
            end else if (bitcnt_reg == 4'd8) begin
              parity_reg <= data_s;
            end else begin
              rx_state_reg <= RX_IDLE;
              if (!frame_ok) begin
                err_reg <= 1'b1;
                idx_reg <= '0;
              end else if (pkt_enable) begin
                // Byte 0 must carry the always-one bit3, which resynchronises the packet stream.
                case (idx_reg)
                  2'd0: begin
                    if (shift_reg[3]) begin
                      byte0_reg <= shift_reg;
                      idx_reg   <= 2'd1;
                    end
                  end
                  2'd1: begin
                    byte1_reg <= shift_reg;
                    idx_reg   <= 2'd2;
                  end
                  2'd2: begin
                    mouse_reg <= {~mouse_reg[24], shift_reg, byte1_reg, byte0_reg};
                    idx_reg   <= 2'd0;
                  end
                  default: idx_reg <= 2'd0;
                endcase
              end
            end
          end
        endcase
      end else if (timeout_hit) begin
        if (rx_state_reg == RX_RECV || idx_reg != 2'd0) begin
          err_reg <= 1'b1;
        end
        rx_state_reg <= RX_IDLE;
        idx_reg      <= '0;
      end
    end
  end

  assign ps2_mouse = mouse_reg;
  assign err       = err_reg;

`ifdef PS2_MOUSE_INIT_EN
  localparam int IW = $clog2(INHIBIT_CYC + 1);
  localparam logic [7:0] TX_CMD = 8'hF4;
  localparam logic [7:0] TX_ACK_BYTE = 8'hFA;

  typedef enum logic [2:0] {TX_INHIBIT, TX_START, TX_BITS, TX_ACK, TX_WAITFA, TX_RUN} tx_state_t;

  tx_state_t     tx_state_reg;
  logic [IW-1:0] inh_cnt_reg;
  logic [3:0]    tx_bit_reg;
  logic          clk_oe_reg;
  logic          data_oe_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_reg <= TX_INHIBIT;
      inh_cnt_reg  <= '0;
      tx_bit_reg   <= '0;
      clk_oe_reg   <= 1'b0;
      data_oe_reg  <= 1'b0;
    end else begin
      case (tx_state_reg)
        TX_INHIBIT: begin
          clk_oe_reg  <= 1'b1;
          data_oe_reg <= 1'b0;
          if (inh_cnt_reg == IW'(INHIBIT_CYC - 1)) begin
            data_oe_reg  <= 1'b1;
            tx_state_reg <= TX_START;
          end else begin
            inh_cnt_reg <= inh_cnt_reg + 1'b1;
          end
        end
        TX_START: begin
          clk_oe_reg   <= 1'b0;
          tx_bit_reg   <= '0;
          tx_state_reg <= TX_BITS;
        end
        TX_BITS: begin
          if (fall_reg) begin
            tx_bit_reg <= tx_bit_reg + 1'b1;
            if (tx_bit_reg < 4'd8) begin
              data_oe_reg <= ~TX_CMD[tx_bit_reg[2:0]];
            end else if (tx_bit_reg == 4'd8) begin
              data_oe_reg <= ^TX_CMD;
            end else begin
              data_oe_reg  <= 1'b0;
              tx_state_reg <= TX_ACK;
            end
          end else if (timeout_hit) begin
            tx_state_reg <= TX_INHIBIT;
            inh_cnt_reg  <= '0;
            data_oe_reg  <= 1'b0;
          end
        end
        TX_ACK: begin
          if (fall_reg && !data_s) begin
            tx_state_reg <= TX_WAITFA;
          end else if (timeout_hit) begin
            tx_state_reg <= TX_INHIBIT;
            inh_cnt_reg  <= '0;
          end
        end
        TX_WAITFA: begin
          if (good_byte && shift_reg == TX_ACK_BYTE) begin
            tx_state_reg <= TX_RUN;
          end else if (timeout_hit) begin
            tx_state_reg <= TX_INHIBIT;
            inh_cnt_reg  <= '0;
          end
        end
        default: tx_state_reg <= TX_RUN;
      endcase
    end
  end

  assign ps2_clk_oe  = clk_oe_reg;
  assign ps2_data_oe = data_oe_reg;
  assign rx_enable   = (tx_state_reg == TX_WAITFA) || (tx_state_reg == TX_RUN);
  assign pkt_enable  = (tx_state_reg == TX_RUN);
  assign to_clear    = (tx_state_reg == TX_START);
`else
  assign ps2_clk_oe  = 1'b0;
  assign ps2_data_oe = 1'b0;
  assign rx_enable   = 1'b1;
  assign pkt_enable  = 1'b1;
  assign to_clear    = 1'b0;
`endif

endmodule
